ysyx_23060191_mdu_seq: RTL and testbench



---
 rtl/ysyx_23060191_mdu_pkg.sv | 48 ++++
 rtl/ysyx_23060191_mdu_step.sv | 37 +++
 rtl/ysyx_23060191_mdu_seq.sv | 176 +++++++++++++++++
 tb/tb_ysyx_23060191_mdu_seq.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060191_mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: op encodings,
// FSM states, iteration count and op-class helpers.
package ysyx_23060191_mdu_pkg;

  localparam int CPU_WIDTH     = 32;
  localparam int MDU_ITER      = 32;
  localparam int ALU_OPT_WIDTH = 5;
  localparam int CNT_WIDTH     = 5;

  typedef logic [ALU_OPT_WIDTH-1:0] alu_op_t;

  // Encodings shared with the single-cycle ALU.
  localparam alu_op_t ALU_MUL   = 5'd10;
  localparam alu_op_t ALU_MULH  = 5'd11;
  localparam alu_op_t ALU_MULHU = 5'd12;
  localparam alu_op_t ALU_DIV   = 5'd13;
  localparam alu_op_t ALU_DIVU  = 5'd14;
  localparam alu_op_t ALU_REM   = 5'd15;
  localparam alu_op_t ALU_REMU  = 5'd16;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_e;

  function automatic logic is_mul_op(input alu_op_t op);
    return op inside {ALU_MUL, ALU_MULH, ALU_MULHU};
  endfunction

  function automatic logic is_div_op(input alu_op_t op);
    return op inside {ALU_DIV, ALU_DIVU};
  endfunction

  function automatic logic is_rem_op(input alu_op_t op);
    return op inside {ALU_REM, ALU_REMU};
  endfunction

  function automatic logic is_signed_op(input alu_op_t op);
    return op inside {ALU_MULH, ALU_DIV, ALU_REM};
  endfunction

endpackage

// File: rtl/ysyx_23060191_mdu_step.sv
// One iteration of shift-add multiply or restoring shift-subtract divide on
// the {hi, lo} accumulator.
module ysyx_23060191_mdu_step
  import ysyx_23060191_mdu_pkg::*;
(
  input  step_mode_e               mode,
  input  logic [2*CPU_WIDTH-1:0]   acc_i,
  input  logic [CPU_WIDTH-1:0]     operand_i,
  output logic [2*CPU_WIDTH-1:0]   acc_o,
  output logic                     q_bit_o
);

  logic [CPU_WIDTH:0] sum;
  logic [CPU_WIDTH:0] shifted;
  logic [CPU_WIDTH:0] diff;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    acc_o   = '0;
    q_bit_o = 1'b0;
    sum     = {1'b0, acc_i[2*CPU_WIDTH-1:CPU_WIDTH]}
            + {1'b0, (acc_i[0] ? operand_i : {CPU_WIDTH{1'b0}})};
    // shifted < 2*divisor, so a 33-bit difference cannot overflow its sign.
    shifted = acc_i[2*CPU_WIDTH-1:CPU_WIDTH-1];
    diff    = shifted - {1'b0, operand_i};

    if (mode == STEP_MUL) begin
      acc_o = {sum, acc_i[CPU_WIDTH-1:1]};
    end else begin
      q_bit_o = ~diff[CPU_WIDTH];
      acc_o   = {(q_bit_o ? diff[CPU_WIDTH-1:0] : shifted[CPU_WIDTH-1:0]),
                 acc_i[CPU_WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/ysyx_23060191_mdu_seq.sv
// Iterative RV32M multiply/divide unit with valid/ready handshakes; owns the
// FSM, iteration counter, sign handling and divide fast paths.
module ysyx_23060191_mdu_seq
  import ysyx_23060191_mdu_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [ALU_OPT_WIDTH-1:0] i_op,
  input  logic [CPU_WIDTH-1:0]     i_src1,
  input  logic [CPU_WIDTH-1:0]     i_src2,
  input  logic                     i_flush,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [CPU_WIDTH-1:0]     o_res,
  output logic                     o_busy
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(MDU_ITER - 1);
  localparam logic [CPU_WIDTH-1:0] INT_MIN  = {1'b1, {(CPU_WIDTH-1){1'b0}}};

  mdu_state_e             state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  alu_op_t                op_q, op_d;
  logic                   neg_q, neg_d;
  logic [2*CPU_WIDTH-1:0] acc_q, acc_d;
  logic [CPU_WIDTH-1:0]   operand_q, operand_d;
  logic [CPU_WIDTH-1:0]   res_q, res_d;
  logic                   valid_q, valid_d;

  step_mode_e             step_mode;
  logic [2*CPU_WIDTH-1:0] step_acc;
  logic                   step_q_bit;
  logic [2*CPU_WIDTH-1:0] acc_next;
  logic [2*CPU_WIDTH-1:0] prod;
  logic [CPU_WIDTH-1:0]   final_res;

  logic                   s1, s2;
  logic [CPU_WIDTH-1:0]   mag1, mag2;

  assign step_mode = is_mul_op(op_q) ? STEP_MUL : STEP_DIV;

  ysyx_23060191_mdu_step u_step (
    .mode      (step_mode),
    .acc_i     (acc_q),
    .operand_i (operand_q),
    .acc_o     (step_acc),
    .q_bit_o   (step_q_bit)
  );

  // The step leaves bit 0 clear when dividing; the quotient bit lands here.
  assign acc_next = {step_acc[2*CPU_WIDTH-1:1], step_acc[0] | step_q_bit};

  // Sign fixup and result selection for the last iteration.
  always_comb begin
    prod      = neg_q ? (~acc_next + 1'b1) : acc_next;
    final_res = '0;
    case (op_q)
      ALU_MUL:              final_res = prod[CPU_WIDTH-1:0];
      ALU_MULH, ALU_MULHU:  final_res = prod[2*CPU_WIDTH-1:CPU_WIDTH];
      ALU_DIV, ALU_DIVU:    final_res = neg_q ? (~acc_next[CPU_WIDTH-1:0] + 1'b1)
                                              : acc_next[CPU_WIDTH-1:0];
      ALU_REM, ALU_REMU:    final_res = neg_q ? (~acc_next[2*CPU_WIDTH-1:CPU_WIDTH] + 1'b1)
                                              : acc_next[2*CPU_WIDTH-1:CPU_WIDTH];
      default:              final_res = '0;
    endcase
  end

  always_comb begin
    s1   = is_signed_op(i_op) & i_src1[CPU_WIDTH-1];
    s2   = is_signed_op(i_op) & i_src2[CPU_WIDTH-1];
    mag1 = s1 ? (~i_src1 + 1'b1) : i_src1;
    mag2 = s2 ? (~i_src2 + 1'b1) : i_src2;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_d     = neg_q;
    acc_d     = acc_q;
    operand_d = operand_q;
    res_d     = res_q;
    valid_d   = valid_q;

    case (state_q)
      MDU_IDLE: begin
        if (i_valid && !i_flush) begin
          op_d  = i_op;
          cnt_d = '0;
          neg_d = is_rem_op(i_op) ? s1 : (s1 ^ s2);
          if (is_mul_op(i_op)) begin
            acc_d     = {{CPU_WIDTH{1'b0}}, mag2};
            operand_d = mag1;
            state_d   = MDU_CALC;
          end else if (is_div_op(i_op) || is_rem_op(i_op)) begin
            if (i_src2 == '0) begin
              res_d   = is_div_op(i_op) ? '1 : i_src1;
              valid_d = 1'b1;
              state_d = MDU_DONE;
            end else if (is_signed_op(i_op) && i_src1 == INT_MIN && i_src2 == '1) begin
              res_d   = is_div_op(i_op) ? INT_MIN : '0;
              valid_d = 1'b1;
              state_d = MDU_DONE;
            end else begin
              acc_d     = {{CPU_WIDTH{1'b0}}, mag1};
              operand_d = mag2;
              state_d   = MDU_CALC;
            end
          end else begin
            res_d   = '0;
            valid_d = 1'b1;
            state_d = MDU_DONE;
          end
        end
      end
      MDU_CALC: begin
        acc_d = acc_next;
        if (cnt_q == CNT_LAST) begin
          res_d   = final_res;
          valid_d = 1'b1;
          state_d = MDU_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MDU_DONE: begin
        if (i_ready) begin
          valid_d = 1'b0;
          state_d = MDU_IDLE;
        end
      end
      default: state_d = MDU_IDLE;
    endcase

    // Flush wins over accept and handoff; o_res and cnt keep their values.
    if (i_flush) begin
      state_d = MDU_IDLE;
      valid_d = 1'b0;
      res_d   = res_q;
      cnt_d   = cnt_q;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      valid_q <= valid_d;
    end
  end

  // NOTE: datapath registers are always loaded at accept before being read,
  // so they carry no reset.
  always_ff @(posedge i_clk) begin
    op_q      <= op_d;
    neg_q     <= neg_d;
    acc_q     <= acc_d;
    operand_q <= operand_d;
  end

  assign o_ready = (state_q == MDU_IDLE);
  assign o_busy  = (state_q != MDU_IDLE);
  assign o_valid = valid_q;
  assign o_res   = res_q;

endmodule

// File: tb/tb_ysyx_23060191_mdu_seq.sv
// Scoreboard bench for the multiply/divide sequencer: results, latency,
// back-pressure, flush and reset behaviour.
module tb_ysyx_23060191_mdu_seq;
  import ysyx_23060191_mdu_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [4:0]  i_op;
  logic [31:0] i_src1;
  logic [31:0] i_src2;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_res;
  logic        o_busy;

  always #5 i_clk = ~i_clk;

  ysyx_23060191_mdu_seq dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_op    (i_op),
    .i_src1  (i_src1),
    .i_src2  (i_src2),
    .i_flush (i_flush),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_res   (o_res),
    .o_busy  (o_busy)
  );

  typedef struct {
    string       tag;
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one request, wait for the result, compare, then release (after an
  // optional stall during which another request is held pending).
  task automatic do_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                       input int stall);
    exp_t e;
    int   lat;
    i_ready = (stall == 0);
    @(negedge i_clk);
    check({tag, "_ready"}, o_ready, 1);
    i_valid = 1'b1;
    i_op    = op;
    i_src1  = a;
    i_src2  = b;
    sb.push_back('{tag, exp, exp_lat});
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_op    = 5'($urandom);
    i_src1  = $urandom;
    i_src2  = $urandom;
    lat = 0;
    do begin
      @(negedge i_clk);
      lat++;
    end while (!o_valid && lat < 100);
    e = sb.pop_front();
    check({e.tag, "_valid"}, o_valid, 1);
    check({e.tag, "_res"}, o_res, e.res);
    check({e.tag, "_lat"}, lat, e.lat);
    if (stall > 0) begin
      i_valid = 1'b1;
      i_op    = ALU_REMU;
      i_src1  = 32'd9;
      i_src2  = 32'd0;
      for (int k = 0; k < stall; k++) begin
        @(negedge i_clk);
        check({e.tag, "_hold_valid"}, o_valid, 1);
        check({e.tag, "_hold_res"}, o_res, e.res);
        check({e.tag, "_hold_ready"}, o_ready, 0);
      end
      i_ready = 1'b1;
      @(negedge i_clk);
      check({e.tag, "_noaccept_valid"}, o_valid, 0);
      check({e.tag, "_noaccept_ready"}, o_ready, 1);
      i_valid = 1'b0;
    end else begin
      @(negedge i_clk);
      check({e.tag, "_release_valid"}, o_valid, 0);
      check({e.tag, "_release_ready"}, o_ready, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_high;
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_flush = 1'b0;
    i_ready = 1'b1;
    i_op    = '0;
    i_src1  = '0;
    i_src2  = '0;
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    @(negedge i_clk);
    check("rst_valid", o_valid, 0);
    check("rst_res", o_res, 0);
    check("rst_busy", o_busy, 0);
    check("rst_ready", o_ready, 1);

    do_op("mul",     ALU_MUL,   32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 0);
    do_op("mulhu",   ALU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 0);
    do_op("mulh",    ALU_MULH,  32'h80000000, 32'h80000000, 32'h40000000, 33, 0);
    do_op("div",     ALU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 0);
    do_op("rem",     ALU_REM,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 0);
    do_op("divu",    ALU_DIVU,  32'hFFFFFFFF, 32'd2,        32'h7FFFFFFF, 33, 0);
    do_op("remu",    ALU_REMU,  32'd100,      32'd7,        32'd2,        33, 0);
    do_op("div_neg", ALU_DIV,   32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 33, 0);
    do_op("rem_pos", ALU_REM,   32'd100,      32'hFFFFFFF9, 32'd2,        33, 0);
    do_op("divu_z",  ALU_DIVU,  32'd5,        32'd0,        32'hFFFFFFFF, 1,  0);
    do_op("rem_z",   ALU_REM,   32'd5,        32'd0,        32'd5,        1,  0);
    do_op("div_ovf", ALU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  0);
    do_op("rem_ovf", ALU_REM,   32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  0);
    do_op("bad_op",  5'd31,     32'd123,      32'd456,      32'd0,        1,  0);
    do_op("mulh_bp", ALU_MULH,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 33, 5);

    // Flush in cycle 10 of CALC.
    @(negedge i_clk);
    i_valid = 1'b1; i_op = ALU_DIVU; i_src1 = 32'd100; i_src2 = 32'd7;
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    repeat (10) @(negedge i_clk);
    i_flush = 1'b1;
    @(posedge i_clk);
    #1 i_flush = 1'b0;
    @(negedge i_clk);
    check("flush_ready", o_ready, 1);
    check("flush_busy", o_busy, 0);
    check("flush_valid", o_valid, 0);
    check("flush_res_kept", o_res, 32'hFFFFFFFF);
    n_high = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge i_clk);
      if (o_valid) n_high++;
    end
    check("flush_no_valid", n_high, 0);

    // Flush together with a request in IDLE: nothing accepted.
    @(negedge i_clk);
    i_valid = 1'b1; i_flush = 1'b1; i_op = ALU_REMU; i_src1 = 32'd5; i_src2 = 32'd0;
    @(posedge i_clk);
    #1 begin i_valid = 1'b0; i_flush = 1'b0; end
    @(negedge i_clk);
    check("flush_acc_busy", o_busy, 0);
    check("flush_acc_valid", o_valid, 0);
    check("flush_acc_res", o_res, 32'hFFFFFFFF);

    // Reset during cycle 20 of CALC.
    @(negedge i_clk);
    i_valid = 1'b1; i_op = ALU_MUL; i_src1 = 32'd7; i_src2 = 32'd3;
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    repeat (20) @(negedge i_clk);
    i_rst_n = 1'b0;
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    @(negedge i_clk);
    check("mrst_valid", o_valid, 0);
    check("mrst_res", o_res, 0);
    check("mrst_busy", o_busy, 0);
    check("mrst_ready", o_ready, 1);
    do_op("divu_after_rst", ALU_DIVU, 32'd9, 32'd3, 32'd3, 33, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
